// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit. One bit per cycle (32 CALC cycles) on
// operand magnitudes, then sign correction and HI/LO write-back in FIX.
module mult_div_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [1:0]  mdop,
    input  logic [31:0] portA,
    input  logic [31:0] portB,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdat,
    output logic        busy,
    output logic        done,
    output logic        divzero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op;
    logic        sign_a, sign_b;
    logic [31:0] orig_a, mag_a, mag_b;
    logic [4:0]  cnt;
    logic [63:0] acc, acc_nxt;

    logic        a_neg, b_neg;
    logic [31:0] mag_a_in, mag_b_in;
    logic [32:0] sum, rem_sh;
    logic        rem_ge;
    logic        div_zero;
    logic [63:0] prod;
    logic [31:0] quo, rem, res_hi, res_lo;

    // Operand conditioning at accept: MULT/DIV (mdop[0]=0) work on magnitudes.
    always_comb begin
        a_neg    = ~mdop[0] & portA[31];
        b_neg    = ~mdop[0] & portB[31];
        mag_a_in = a_neg ? (32'd0 - portA) : portA;
        mag_b_in = b_neg ? (32'd0 - portB) : portB;
    end

    // One iteration: shift-add for multiply, restoring step for divide.
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
        rem_sh  = {acc[63:32], acc[31]};
        rem_ge  = (rem_sh >= {1'b0, mag_b});
        acc_nxt = {sum, acc[31:1]};
        if (op[1]) begin
            if (rem_ge) acc_nxt = {rem_sh[31:0] - mag_b, acc[30:0], 1'b1};
            else        acc_nxt = {rem_sh[31:0],         acc[30:0], 1'b0};
        end
    end

    always_comb begin
        div_zero = op[1] & (mag_b == 32'd0);
        prod     = (sign_a ^ sign_b) ? (64'd0 - acc) : acc;
        quo      = (sign_a ^ sign_b) ? (32'd0 - acc[31:0]) : acc[31:0];
        rem      = sign_a ? (32'd0 - acc[63:32]) : acc[63:32];
        res_hi   = prod[63:32];
        res_lo   = prod[31:0];
        if (div_zero) begin
            res_hi = orig_a;
            res_lo = 32'hFFFF_FFFF;
        end else if (op[1]) begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == 5'd0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op      <= 2'b00;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            orig_a  <= 32'd0;
            mag_a   <= 32'd0;
            mag_b   <= 32'd0;
            cnt     <= 5'd0;
            acc     <= 64'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done    <= 1'b0;
            divzero <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_hi) hi <= wdat;
                    if (wr_lo) lo <= wdat;
                    if (start) begin
                        op     <= mdop;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        orig_a <= portA;
                        mag_a  <= mag_a_in;
                        mag_b  <= mag_b_in;
                        cnt    <= 5'd31;
                        acc    <= {32'd0, (mdop[1] ? mag_a_in : mag_b_in)};
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 5'd1;
                end
                FIX: begin
                    hi      <= res_hi;
                    lo      <= res_lo;
                    done    <= 1'b1;
                    divzero <= div_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, latency, write-strobe
// rules, start-while-busy and mid-operation reset.
module tb_mult_div_unit;

    logic        clk, rst, start, wr_hi, wr_lo;
    logic [1:0]  mdop;
    logic [31:0] port_a, port_b, wdat;
    logic        busy, done, divzero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    mult_div_unit dut (
        .CLK(clk), .RST(rst), .start(start), .mdop(mdop),
        .portA(port_a), .portB(port_b), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdat(wdat),
        .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one edge (E0); operands are scrambled afterwards.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        mdop = op; port_a = a; port_b = b; start = 1'b1;
        step();
        start = 1'b0; port_a = $urandom; port_b = $urandom; mdop = 2'($urandom);
    endtask

    // Called #1 after E0: waits (bounded) for done; reports cycles and busy count.
    task automatic wait_done(output int cyc, output int busy_cnt, output int dz_early);
        cyc = 0; busy_cnt = 0; dz_early = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            if (divzero) dz_early = 1;
            step();
            cyc++;
        end
    endtask

    int cyc, bc, dz, cyc2, seen_done;

    initial begin
        rst = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        mdop = 2'b00; port_a = '0; port_b = '0; wdat = '0;
        step(); step();
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_divzero", 32'(divzero), 32'h0);
        rst = 1'b0;
        step();

        // MULTU max * max
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, bc, dz);
        check("multu_latency", 32'(cyc), 32'd33);
        check("multu_busy_cycles", 32'(bc), 32'd33);
        check("multu_busy_in_done", 32'(busy), 32'h0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        step();
        check("done_pulse_width", 32'(done), 32'h0);

        // MULT -3 * 7
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(cyc, bc, dz);
        check("mult_latency", 32'(cyc), 32'd33);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        step();

        // DIV -7 / 2
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, bc, dz);
        check("div_latency", 32'(cyc), 32'd33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        step();

        // DIVU 100 / 0
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_done(cyc, bc, dz);
        check("dz_latency", 32'(cyc), 32'd33);
        check("dz_early", 32'(dz), 32'h0);
        check("dz_flag", 32'(divzero), 32'h1);
        check("dz_hi", hi, 32'h0000_0064);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        step();
        check("dz_flag_clear", 32'(divzero), 32'h0);

        // DIV min / -1, then MULTU started in the done cycle
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, bc, dz);
        check("wrap_latency", 32'(cyc), 32'd33);
        check("wrap_lo", lo, 32'h8000_0000);
        check("wrap_hi", hi, 32'h0);
        check("wrap_divzero", 32'(divzero), 32'h0);
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        wait_done(cyc, bc, dz);
        check("b2b_latency", 32'(cyc + 1), 32'd34);
        check("b2b_hi", hi, 32'h1);
        check("b2b_lo", lo, 32'h0);
        step();

        // MTHI while idle
        wr_hi = 1'b1; wdat = 32'h1234_5678;
        #1;
        check("mthi_before_edge", hi, 32'h1);
        step();
        wr_hi = 1'b0;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo_kept", lo, 32'h0);

        // MTLO with accepted start, then wr_lo and start mid-CALC are dropped
        wr_lo = 1'b1; wdat = 32'h0000_AAAA;
        issue(OP_DIVU, 32'd1000, 32'd3);
        wr_lo = 1'b0;
        check("mtlo_with_start", lo, 32'h0000_AAAA);
        check("busy_after_start", 32'(busy), 32'h1);
        for (int i = 0; i < 5; i++) step();
        wr_lo = 1'b1; wr_hi = 1'b1; wdat = 32'hDEAD_BEEF;
        mdop = OP_MULTU; port_a = 32'd5; port_b = 32'd5; start = 1'b1;
        step();
        wr_lo = 1'b0; wr_hi = 1'b0; start = 1'b0;
        check("busy_lo_dropped", lo, 32'h0000_AAAA);
        check("busy_hi_dropped", hi, 32'h1234_5678);
        wait_done(cyc, bc, dz);
        check("midcalc_latency", 32'(cyc + 6), 32'd33);
        check("midcalc_lo", lo, 32'd333);
        check("midcalc_hi", hi, 32'd1);
        step();

        // Reset mid-CALC
        issue(OP_DIVU, 32'd1000, 32'd3);
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        #2;
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        step();
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen_done = 1;
            step();
        end
        check("abort_no_done", 32'(seen_done), 32'h0);
        issue(OP_DIVU, 32'd1000, 32'd3);
        wait_done(cyc2, bc, dz);
        check("fresh_latency", 32'(cyc2), 32'd33);
        check("fresh_lo", lo, 32'd333);
        check("fresh_hi", hi, 32'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit serving the MIPS MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO instructions. The execute stage issues operands and an opcode with a start pulse. The unit iterates one bit per cycle, writes the 64-bit result into its architectural HI/LO registers and pulses done. HI/LO are always readable, so MFHI/MFLO are plain reads gated by busy in the hazard logic.

## Interface
Parameters:
- none (datapath fixed at 32 bits, result 64 bits)

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- start  in  1  begin operation when sampled high while idle
- mdop  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- portA  in  32  multiplicand / dividend (rs)
- portB  in  32  multiplier / divisor (rt)
- wr_hi  in  1  MTHI write strobe
- wr_lo  in  1  MTLO write strobe
- wdat  in  32  data for wr_hi / wr_lo
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: HI/LO just updated by an operation
- divzero  out  1  valid with done; divisor was zero
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, CALC, FIX.
- **IDLE.** start=1 latches portA, portB and mdop, loads iteration counter = 31, clears the accumulator, then moves to CALC. For signed ops (MULT, DIV), operands are converted to magnitudes and the sign flags are latched.
- **CALC.** Runs 32 cycles, one bit per cycle.
  - Multiply: shift-add on magnitudes into a 64-bit product.
  - Divide: restoring division on magnitudes, producing a 32-bit quotient and 32-bit remainder.
  - Counter decrements each cycle. On counter = 0, moves to FIX.
- **FIX.** Applies sign correction, writes HI/LO, asserts done for one cycle, then returns to IDLE.
  - MULT: product negated (64-bit two's complement) if signA ^ signB.
  - DIV: quotient negated if signA ^ signB; remainder negated if signA.
  - HI/LO mapping:
    - Multiply: HI = product[63:32], LO = product[31:0].
    - Divide: HI = remainder, LO = quotient.
- **Divide by zero** (portB = 0): no sign correction. Result is HI = portA (original value), LO = 0xFFFFFFFF, divzero = 1 for the done cycle. The iteration still takes the full 32 cycles.
- **DIV 0x80000000 / 0xFFFFFFFF:** result is LO = 0x80000000, HI = 0. This is the natural wrap; no trap.
- **start while busy:** ignored, with no effect on the operation in flight.
- **wr_hi / wr_lo:**
  - Honoured only when busy = 0; dropped while busy.
  - Both may fire in the same cycle.
  - If asserted in the same cycle as an accepted start, the write occurs and the operation still launches; its FIX overwrites both registers.
- **Arithmetic width.** All arithmetic is unsigned on 32-bit magnitudes. abs(0x80000000) = 0x80000000, treated as unsigned.

## Timing
- Reset values:
  - hi = 0, lo = 0.
  - busy = 0, done = 0, divzero = 0.
  - State IDLE.
- **Reset mid-operation:** aborts immediately. All outputs and state return to their reset values; no partial HI/LO update.
- **Accept and latency:**
  - Start is accepted at edge E0.
  - busy = 1 after E0 through E33.
  - CALC edges are E1..E32; FIX is at E33.
  - hi/lo update and done = 1 take effect after E33, for one cycle. busy = 0 in that same cycle.
- **Throughput:** a new start may be sampled at E34 (the cycle where done is high). Back-to-back operations therefore take 34 cycles each.
- **Outputs:** hi/lo are registered and change only at FIX, on a write strobe, or on reset. done and divzero are registered pulses.
- **Operand stability:** operands need only be valid at the start edge; later changes to portA/portB/mdop have no effect.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> done after E33; HI = 0xFFFFFFFE, LO = 0x00000001; busy high for exactly 33 cycles.
- MULT 0xFFFFFFFD (-3) × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 -> HI = 0x00000064, LO = 0xFFFFFFFF, divzero = 1 only during the done cycle.
- DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0, divzero = 0. Then MULTU 0x10000 × 0x10000 started in the done cycle -> HI = 1, LO = 0 after a further 34 cycles.
- Write and start-while-busy rules:
  - MTHI 0x12345678 while idle -> hi updates next edge.
  - wr_lo and a second start asserted mid-CALC -> ignored; final LO is the original operation's result.
- Assert RST at CALC cycle 10 of DIVU 1000 / 3 -> hi = lo = 0, busy = 0, no done pulse. A fresh DIVU 1000 / 3 after release -> LO = 333, HI = 1.
